// File: rtl/dc_token_pkg.sv
// dc_token_pkg: shared constants and helpers for the token-based clock-domain-crossing FIFO
package dc_token_pkg;
  localparam int DC_BUFFER_WIDTH = 8;
  localparam int DC_SYNC_STAGES = 2;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int slot_lo(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/dc_token_sync.sv
// dc_token_sync: bit-independent multi-flop synchronizer with synchronous active-low reset
module dc_token_sync #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] ff;
  always_ff @(posedge clk_i)
    if (!rst_ni) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/dc_token_fifo_reader.sv
// dc_token_fifo_reader: read end of the token CDC FIFO, pops full slots in order onto a valid/ready stream
module dc_token_fifo_reader
  import dc_token_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BUFFER_WIDTH = DC_BUFFER_WIDTH,
  parameter int SYNC_STAGES = DC_SYNC_STAGES
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [BUFFER_WIDTH-1:0]          writetoken_i,
  input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] buffer_i,
  output logic [BUFFER_WIDTH-1:0]          readpointer_o,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             empty_o
);
  localparam int IW = idx_width(BUFFER_WIDTH);
  logic [IW-1:0] rd_idx;
  logic [BUFFER_WIDTH-1:0] wt_sync;
  logic slot_full, load;
  dc_token_sync #(.WIDTH(BUFFER_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (writetoken_i),
    .q     (wt_sync)
  );
  assign slot_full = wt_sync[rd_idx] ^ readpointer_o[rd_idx];
  assign load = slot_full & (~valid_o | ready_i);
  assign empty_o = ~valid_o & ~slot_full;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      readpointer_o <= '0;
      data_o <= '0;
      valid_o <= 1'b0;
      rd_idx <= '0;
    end else if (load) begin
      data_o <= buffer_i[slot_lo(int'(rd_idx), DATA_WIDTH) +: DATA_WIDTH];
      valid_o <= 1'b1;
      readpointer_o <= readpointer_o ^ (BUFFER_WIDTH'(1) << rd_idx);
      rd_idx <= rd_idx + 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_dc_token_fifo_reader.sv
// tb_dc_token_fifo_reader: scoreboard and table-driven bench for the token CDC FIFO reader
module tb_dc_token_fifo_reader;
  localparam int DW = 64;
  localparam int BW = 8;
  typedef struct {
    logic [BW-1:0] mask;
    logic [DW-1:0] base;
    logic [BW-1:0] exp_rp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, ready, valid, empty;
  logic [BW-1:0] wt, rp;
  logic [BW*DW-1:0] buff;
  logic [DW-1:0] data;
  logic [DW-1:0] q[$];
  logic pv = 1'b0;
  logic [DW-1:0] pd = '0;
  int n_chk = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  vec_t tbl[4];
  always #5 clk = ~clk;
  dc_token_fifo_reader #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW), .SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .writetoken_i (wt),
    .buffer_i     (buff),
    .readpointer_o(rp),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .empty_o      (empty)
  );
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    wt = '0;
    ready = 1'b1;
    repeat (2) nxt();
    q.delete();
    rst_n = 1'b1;
    nxt();
  endtask
  task automatic write_slot(input int i, input logic [DW-1:0] v);
    buff[i*DW +: DW] = v;
    wt[i] = ~wt[i];
    q.push_back(v);
  endtask
  always @(negedge clk) begin
    if (rst_n && pv && ready) begin
      hs_cnt++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got %0h expected no transfer", pd);
      end else chk("pop_data", pd, q.pop_front());
    end
    pv = valid;
    pd = data;
  end
  initial begin
    int c, k, h0;
    tbl[0] = '{8'hFF, 64'd1, 8'hFF};
    tbl[1] = '{8'h03, 64'h11, 8'hFC};
    tbl[2] = '{8'h1C, 64'h21, 8'hE0};
    tbl[3] = '{8'hE0, 64'h31, 8'h00};
    rst_n = 1'b0;
    ready = 1'b1;
    wt = 8'hFF;
    buff = '0;
    for (int i = 0; i < BW; i++) buff[i*DW +: DW] = 64'(100 + i);
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("rst_rp", 64'(rp), 64'h0);
      chk("rst_valid", 64'(valid), 64'h0);
      chk("rst_empty", 64'(empty), 64'h1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < BW; i++) q.push_back(64'(100 + i));
    c = 0;
    while (q.size() != 0 && c < 40) begin nxt(); c++; end
    chk("rst_drain", 64'(q.size()), 64'h0);
    chk("rst_drain_rp", 64'(rp), 64'hFF);
    chk("rst_drain_empty", 64'(empty), 64'h1);
    do_reset();
    write_slot(0, 64'hDEAD_BEEF);
    nxt();
    chk("lat_c1_valid", 64'(valid), 64'h0);
    nxt();
    chk("lat_c2_valid", 64'(valid), 64'h0);
    nxt();
    chk("lat_c3_valid", 64'(valid), 64'h1);
    chk("lat_c3_data", data, 64'hDEAD_BEEF);
    chk("lat_c3_rp", 64'(rp), 64'h01);
    nxt();
    chk("single_after_valid", 64'(valid), 64'h0);
    chk("single_after_empty", 64'(empty), 64'h1);
    do_reset();
    for (int r = 0; r < 4; r++) begin
      k = 0;
      for (int i = 0; i < BW; i++)
        if (tbl[r].mask[i]) begin
          write_slot(i, tbl[r].base + 64'(k));
          k++;
        end
      c = 0;
      while (!valid && c < 10) begin nxt(); c++; end
      chk("row_valid", 64'(valid), 64'h1);
      c = 0;
      while (q.size() != 0 && c < 20) begin nxt(); c++; end
      chk("row_cycles", 64'(c), 64'(k));
      chk("row_rp", 64'(rp), 64'(tbl[r].exp_rp));
      chk("row_valid_end", 64'(valid), 64'h0);
      chk("row_empty", 64'(empty), 64'h1);
    end
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) write_slot(i, 64'hA0 + 64'(i));
    repeat (3) nxt();
    chk("bp_valid", 64'(valid), 64'h1);
    chk("bp_data", data, 64'hA0);
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("bp_hold_valid", 64'(valid), 64'h1);
      chk("bp_hold_data", data, 64'hA0);
      chk("bp_hold_rp", 64'(rp), 64'h01);
    end
    ready = 1'b1;
    nxt();
    chk("bp_rel1_data", data, 64'hA1);
    chk("bp_rel1_rp", 64'(rp), 64'h03);
    nxt();
    chk("bp_rel2_data", data, 64'hA2);
    chk("bp_rel2_rp", 64'(rp), 64'h07);
    nxt();
    chk("bp_end_valid", 64'(valid), 64'h0);
    chk("bp_end_q", 64'(q.size()), 64'h0);
    do_reset();
    for (int i = 0; i < 4; i++) write_slot(i, 64'hB0 + 64'(i));
    h0 = hs_cnt;
    c = 0;
    while (hs_cnt - h0 < 2 && c < 20) begin nxt(); c++; end
    chk("mid_two_pops", 64'(hs_cnt - h0), 64'h2);
    rst_n = 1'b0;
    wt = '0;
    nxt();
    chk("mid_rst_valid", 64'(valid), 64'h0);
    chk("mid_rst_rp", 64'(rp), 64'h0);
    q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt();
      chk("mid_quiet_valid", 64'(valid), 64'h0);
      chk("mid_quiet_empty", 64'(empty), 64'h1);
    end
    chk("final_q", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
